pcie_us_msi_sched: RTL and testbench
====================================

Name: pcie_us_msi_sched

Overview:
- Shares the UltraScale PCIe hard-IP MSI request interface (cfg_interrupt_msi_*) between IRQ_COUNT interrupt sources.
- Latches each interrupt pulse as a pending bit, picks one pending source round-robin and drives one vector bit on cfg_interrupt_msi_int.
- Waits for sent/fail from the IP and retries failed deliveries after a backoff.
- Sits between the application core and the PCIe IP interrupt ports, function 0 only.

Parameters:
- IRQ_COUNT, 32: number of interrupt sources, 1..32.
- RETRY_DELAY, 16: cycles in BACKOFF after fail before re-arbitration, >=1.
- TIMEOUT, 1024: WAIT watchdog limit in cycles. Used only with the optional feature.

Ports:
- clk  in  1  core clock, 250 MHz.
- rst  in  1  reset, asynchronous, active-high.
- irq  in  IRQ_COUNT  per-source request pulses, one cycle each.
- cfg_interrupt_msi_enable  in  4  bit 0 = MSI enabled for function 0.
- cfg_interrupt_msi_mmenable  in  12  bits [2:0] = log2 of allocated vectors for function 0.
- cfg_interrupt_msi_int  out  32  one-hot vector request to the IP.
- cfg_interrupt_msi_sent  in  1  delivery complete.
- cfg_interrupt_msi_fail  in  1  delivery failed.
- cfg_interrupt_msi_select  out  4  constant 0.
- cfg_interrupt_msi_function_number  out  4  constant 0.
- pending  out  IRQ_COUNT  current pending bits.
- busy  out  1  high when not IDLE.
- fail_count  out  16  saturating count of fail events.

Behaviour:
- Reset: pending=0, cfg_interrupt_msi_int=0, busy=0, fail_count=0, state=IDLE, round-robin pointer=0, backoff counter=0.
- Pending update every cycle: pending <= (pending & ~clr) | irq.
  - clr is one-hot on the granted source in the cycle sent is seen, zero otherwise.
  - A new irq on the granted source in the same cycle as sent leaves its bit set: one extra MSI follows.
  - Repeated pulses while a bit is already pending merge into one MSI.
- Vector map: alloc = 1 << min(mmenable[2:0], 5). Source i uses vector (i & (alloc-1)).
- States:
  - IDLE: if msi_enable[0] and pending != 0, grant = first pending index at or after the pointer, wrapping modulo IRQ_COUNT; go to ISSUE. If msi_enable[0]=0, stay in IDLE; pending bits are retained, never dropped.
  - ISSUE: exactly one cycle. cfg_interrupt_msi_int = 1 << vector(grant), zero in every other state. Go to WAIT.
  - WAIT: on sent, clear pending[grant], set pointer = grant+1 (wrapping at IRQ_COUNT), go to IDLE. On fail, increment fail_count (saturate at 0xFFFF), load backoff = RETRY_DELAY, go to BACKOFF; pending[grant] stays set and the pointer is unchanged, so the same source retries first. If sent and fail are both high, sent wins.
  - BACKOFF: decrement each cycle; at 0 go to IDLE.
- Latency: irq pulse at cycle N, IDLE and MSI enabled -> cfg_interrupt_msi_int asserted at cycle N+2.
- msi_enable[0] deasserting in WAIT or BACKOFF: the current transaction finishes normally; no new grant is made until it re-asserts.
- mmenable changes take effect at the next ISSUE.
- Async reset in any state returns to the reset values immediately; the IP sees int drop to 0.

Optional Feature:
- Macro MSI_SCHED_TIMEOUT_EN.
- Defined: a WAIT counter starts at ISSUE. If TIMEOUT cycles pass in WAIT with neither sent nor fail, the block handles it exactly as a fail: fail_count increments and the state moves to BACKOFF.
- Not defined: no counter exists and WAIT holds indefinitely. TIMEOUT is ignored.

Test Plan:
- Single source: mmenable=5, enable=1, irq[3] pulse at cycle 10 -> msi_int=0x8 at cycle 12 for one cycle; sent at 15 -> pending=0, busy=0 at 16.
- Round-robin: irq=0x00000005 in one cycle, sent returned 3 cycles after each ISSUE -> vectors issued in order 0x1 then 0x4; a following irq[0] and irq[2] together are served source 0 first (pointer=3 wraps to 0).
- Fail/retry: irq[1], fail after ISSUE -> BACKOFF for 16 cycles, msi_int=0x2 re-issued, fail_count=1; sent -> pending[1] cleared.
- Vector fold: mmenable=2 (4 vectors), irq[6] -> msi_int=0x4. MSI disabled: irq[0] pulse -> no issue and pending[0]=1; enable raised -> issue 2 cycles later.
- Merge/race: irq[2] pulsed 3 times before grant -> one MSI; irq[2] in the same cycle as its sent -> second MSI follows.
- Timeout (macro defined, TIMEOUT=8): no response after ISSUE -> BACKOFF entered 8 cycles later, fail_count=1. Async rst asserted in WAIT -> all outputs 0 in the same cycle.

Source files
------------

// File: rtl/pcie_us_msi_sched.sv
// pcie_us_msi_sched: shares the UltraScale PCIe MSI request port (function 0) between
// IRQ_COUNT pulse sources. Pending bits are granted round-robin, one vector per MSI,
// and failed deliveries are retried after a RETRY_DELAY backoff.
// Optional build macro MSI_SCHED_TIMEOUT_EN: adds a WAIT watchdog of TIMEOUT cycles
// that is treated exactly like a fail response.
module pcie_us_msi_sched #(
    parameter int unsigned IRQ_COUNT   = 32,
    parameter int unsigned RETRY_DELAY = 16,
    parameter int unsigned TIMEOUT     = 1024
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [IRQ_COUNT-1:0] irq,
    input  logic [3:0]           cfg_interrupt_msi_enable,
    input  logic [11:0]          cfg_interrupt_msi_mmenable,
    output logic [31:0]          cfg_interrupt_msi_int,
    input  logic                 cfg_interrupt_msi_sent,
    input  logic                 cfg_interrupt_msi_fail,
    output logic [3:0]           cfg_interrupt_msi_select,
    output logic [3:0]           cfg_interrupt_msi_function_number,
    output logic [IRQ_COUNT-1:0] pending,
    output logic                 busy,
    output logic [15:0]          fail_count
);

    localparam int IW = (IRQ_COUNT > 1) ? $clog2(IRQ_COUNT) : 1;
    localparam int BW = $clog2(RETRY_DELAY + 1);

    typedef enum logic [1:0] {StIdle, StIssue, StWait, StBackoff} state_t;

    state_t               state_q;
    logic [IRQ_COUNT-1:0] pending_q;
    logic [IRQ_COUNT-1:0] pending_d;
    logic [IRQ_COUNT-1:0] clr;
    logic [IW-1:0]        ptr_q;
    logic [IW-1:0]        grant_q;
    logic [IW-1:0]        pick;
    logic                 found;
    logic [31:0]          msi_int_q;
    logic                 busy_q;
    logic [15:0]          fail_count_q;
    logic [BW-1:0]        backoff_q;
    logic                 msi_en;
    logic                 wait_fail;

    // Only function 0 is served; upper enable/mmenable bits belong to other functions.
    logic unused_cfg;
    assign unused_cfg = ^{cfg_interrupt_msi_enable[3:1], cfg_interrupt_msi_mmenable[11:3]};

    assign msi_en = cfg_interrupt_msi_enable[0];

    // Fold a source index onto the allocated vector range and return the one-hot request.
    function automatic logic [31:0] vec_onehot(input logic [IW-1:0] src, input logic [2:0] mm);
        logic [2:0] lg;
        logic [4:0] mask;
        logic [4:0] v;
        lg   = (mm > 3'd5) ? 3'd5 : mm;
        mask = 5'((6'd1 << lg) - 6'd1);
        v    = 5'(src) & mask;
        return 32'd1 << v;
    endfunction

    // Round-robin search: first pending index at or after the pointer, wrapping.
    always_comb begin
        found = 1'b0;
        pick  = '0;
        for (int i = 0; i < int'(IRQ_COUNT); i++) begin
            int idx;
            idx = (int'(ptr_q) + i) % int'(IRQ_COUNT);
            if (!found && pending_q[idx]) begin
                found = 1'b1;
                pick  = IW'(idx);
            end
        end
    end

    // Clear the granted bit only on sent; a same-cycle irq re-sets it via the OR.
    always_comb begin
        clr = '0;
        if (state_q == StWait && cfg_interrupt_msi_sent) begin
            clr[grant_q] = 1'b1;
        end
        pending_d = (pending_q & ~clr) | irq;
    end

`ifdef MSI_SCHED_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT + 1);
    logic [TW-1:0] wait_cnt_q;
    logic          timed_out;

    assign timed_out = (wait_cnt_q == TW'(TIMEOUT - 1));
    assign wait_fail = cfg_interrupt_msi_fail | timed_out;

    // WAIT watchdog: cleared in ISSUE, counts every WAIT cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wait_cnt_q <= '0;
        end else if (state_q == StIssue) begin
            wait_cnt_q <= '0;
        end else if (state_q == StWait && !timed_out) begin
            wait_cnt_q <= wait_cnt_q + 1'b1;
        end
    end
`else
    localparam int unsigned unused_timeout = TIMEOUT;
    assign wait_fail = cfg_interrupt_msi_fail;
`endif

    // Main FSM with registered outputs and pending-bit state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= StIdle;
            pending_q    <= '0;
            ptr_q        <= '0;
            grant_q      <= '0;
            msi_int_q    <= '0;
            busy_q       <= 1'b0;
            fail_count_q <= '0;
            backoff_q    <= '0;
        end else begin
            pending_q <= pending_d;
            case (state_q)
                StIdle: begin
                    if (msi_en && found) begin
                        grant_q   <= pick;
                        msi_int_q <= vec_onehot(pick, cfg_interrupt_msi_mmenable[2:0]);
                        busy_q    <= 1'b1;
                        state_q   <= StIssue;
                    end
                end
                StIssue: begin
                    msi_int_q <= '0;
                    state_q   <= StWait;
                end
                StWait: begin
                    // sent has priority over fail when both arrive together.
                    if (cfg_interrupt_msi_sent) begin
                        ptr_q   <= (grant_q == IW'(IRQ_COUNT - 1)) ? '0 : grant_q + 1'b1;
                        busy_q  <= 1'b0;
                        state_q <= StIdle;
                    end else if (wait_fail) begin
                        if (fail_count_q != 16'hFFFF) begin
                            fail_count_q <= fail_count_q + 16'd1;
                        end
                        backoff_q <= BW'(RETRY_DELAY);
                        state_q   <= StBackoff;
                    end
                end
                StBackoff: begin
                    // Pointer untouched, so the failed source is granted again first.
                    if (backoff_q <= BW'(1)) begin
                        backoff_q <= '0;
                        busy_q    <= 1'b0;
                        state_q   <= StIdle;
                    end else begin
                        backoff_q <= backoff_q - 1'b1;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign cfg_interrupt_msi_int             = msi_int_q;
    assign cfg_interrupt_msi_select          = 4'd0;
    assign cfg_interrupt_msi_function_number = 4'd0;
    assign pending                           = pending_q;
    assign busy                              = busy_q;
    assign fail_count                        = fail_count_q;

endmodule

// File: tb/tb_pcie_us_msi_sched.sv
// Bench for pcie_us_msi_sched: expected MSI vectors are queued as irqs are driven and
// popped by a monitor each time the DUT raises cfg_interrupt_msi_int.
module tb_pcie_us_msi_sched;

    localparam int N = 32;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [N-1:0]  irq = '0;
    logic [3:0]    en = 4'd0;
    logic [11:0]   mm = 12'd5;
    logic [31:0]   msi_int;
    logic          sent = 1'b0;
    logic          fail = 1'b0;
    logic [3:0]    sel;
    logic [3:0]    fnum;
    logic [N-1:0]  pending;
    logic          busy;
    logic [15:0]   fail_count;

    int            errors = 0;
    int            checks = 0;
    int            exp_fail = 0;
    logic [31:0]   sb[$];

    pcie_us_msi_sched #(
        .IRQ_COUNT  (N),
        .RETRY_DELAY(16),
        .TIMEOUT    (8)
    ) dut (
        .clk                              (clk),
        .rst                              (rst),
        .irq                              (irq),
        .cfg_interrupt_msi_enable         (en),
        .cfg_interrupt_msi_mmenable       (mm),
        .cfg_interrupt_msi_int            (msi_int),
        .cfg_interrupt_msi_sent           (sent),
        .cfg_interrupt_msi_fail           (fail),
        .cfg_interrupt_msi_select         (sel),
        .cfg_interrupt_msi_function_number(fnum),
        .pending                          (pending),
        .busy                             (busy),
        .fail_count                       (fail_count)
    );

    always #5 clk = ~clk;

    // Scoreboard monitor: every issued vector must match the oldest queued expectation.
    always @(negedge clk) begin
        if (!rst && msi_int !== 32'd0) begin
            checks++;
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL sb_unexpected: got msi_int=%h, required none", msi_int);
            end else begin
                logic [31:0] e;
                e = sb.pop_front();
                if (msi_int !== e) begin
                    errors++;
                    $display("FAIL sb_vector: got msi_int=%h, required %h", msi_int, e);
                end
            end
        end
    end

    task automatic step();
        @(negedge clk);
    endtask

    task automatic pulse_irq(input logic [N-1:0] m);
        irq = m;
        step();
        irq = '0;
    endtask

    // Steps until an MSI is visible; n is the number of steps taken.
    task automatic wait_issue(output int n);
        n = 0;
        while (msi_int === 32'd0 && n < 200) begin
            step();
            n++;
        end
        if (msi_int === 32'd0) begin
            errors++;
            checks++;
            $display("FAIL wait_issue: got no MSI within %0d cycles, required one", n);
        end
    endtask

    // Called mid-ISSUE; answers with sent or fail 'delay' cycles after ISSUE.
    task automatic respond(input int delay, input bit is_fail);
        repeat (delay - 1) step();
        if (is_fail) fail = 1'b1;
        else         sent = 1'b1;
        step();
        sent = 1'b0;
        fail = 1'b0;
    endtask

    task automatic serve(input int delay, input bit is_fail);
        int n;
        wait_issue(n);
        respond(delay, is_fail);
    endtask

    task automatic test_reset();
        checks++;
        if ({msi_int, pending, busy, fail_count, sel, fnum} !== '0) begin
            errors++;
            $display("FAIL reset_state: got int=%h pend=%h busy=%b fc=%0d sel=%h fn=%h, required 0",
                     msi_int, pending, busy, fail_count, sel, fnum);
        end
    endtask

    task automatic test_single();
        sb.push_back(32'h8);
        pulse_irq(32'h8);
        checks++;
        if (msi_int !== 32'd0 || pending !== 32'h8) begin
            errors++;
            $display("FAIL single_n1: got int=%h pend=%h, required 0 / 8", msi_int, pending);
        end
        step();
        checks++;
        if (msi_int !== 32'h8 || busy !== 1'b1) begin
            errors++;
            $display("FAIL single_latency: got int=%h busy=%b, required 8 / 1", msi_int, busy);
        end
        step();
        checks++;
        if (msi_int !== 32'd0) begin
            errors++;
            $display("FAIL single_one_cycle: got int=%h, required 0", msi_int);
        end
        respond(2, 1'b0);
        checks++;
        if (pending !== '0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL single_done: got pend=%h busy=%b, required 0 / 0", pending, busy);
        end
    endtask

    task automatic test_round_robin();
        sb.push_back(32'h1);
        sb.push_back(32'h4);
        pulse_irq(32'h5);
        serve(3, 1'b0);
        serve(3, 1'b0);
        // Pointer now 3: sources 0 and 2 together must serve 0 first.
        sb.push_back(32'h1);
        sb.push_back(32'h4);
        pulse_irq(32'h5);
        serve(3, 1'b0);
        serve(3, 1'b0);
        checks++;
        if (pending !== '0 || sb.size() != 0) begin
            errors++;
            $display("FAIL rr_done: got pend=%h queued=%0d, required 0 / 0", pending, sb.size());
        end
    endtask

    task automatic test_fail_retry();
        int n;
        sb.push_back(32'h2);
        sb.push_back(32'h2);
        pulse_irq(32'h2);
        serve(3, 1'b1);
        exp_fail++;
        checks++;
        if (fail_count !== 16'(exp_fail) || pending !== 32'h2 || busy !== 1'b1) begin
            errors++;
            $display("FAIL retry_backoff: got fc=%0d pend=%h busy=%b, required %0d / 2 / 1",
                     fail_count, pending, busy, exp_fail);
        end
        wait_issue(n);
        // 16 BACKOFF cycles (first already elapsed) + IDLE + ISSUE.
        checks++;
        if (n != 17) begin
            errors++;
            $display("FAIL retry_delay: got %0d cycles to reissue, required 17", n);
        end
        respond(3, 1'b0);
        checks++;
        if (pending !== '0 || fail_count !== 16'(exp_fail)) begin
            errors++;
            $display("FAIL retry_done: got pend=%h fc=%0d, required 0 / %0d",
                     pending, fail_count, exp_fail);
        end
    endtask

    task automatic test_fold_disable();
        int n;
        mm = 12'd2;
        sb.push_back(32'h4);
        pulse_irq(32'h40);
        serve(2, 1'b0);
        mm = 12'd5;
        en = 4'd0;
        pulse_irq(32'h1);
        repeat (6) step();
        checks++;
        if (pending !== 32'h1 || busy !== 1'b0 || msi_int !== 32'd0) begin
            errors++;
            $display("FAIL disabled_hold: got pend=%h busy=%b int=%h, required 1 / 0 / 0",
                     pending, busy, msi_int);
        end
        sb.push_back(32'h1);
        en = 4'd1;
        wait_issue(n);
        checks++;
        if (n < 1 || n > 2) begin
            errors++;
            $display("FAIL enable_latency: got %0d cycles, required 1..2", n);
        end
        respond(2, 1'b0);
    endtask

    task automatic test_merge_race();
        int n;
        en = 4'd0;
        pulse_irq(32'h4);
        step();
        pulse_irq(32'h4);
        pulse_irq(32'h4);
        sb.push_back(32'h4);
        en = 4'd1;
        serve(2, 1'b0);
        repeat (8) step();
        checks++;
        if (pending !== '0 || sb.size() != 0) begin
            errors++;
            $display("FAIL merge: got pend=%h queued=%0d, required 0 / 0", pending, sb.size());
        end
        // irq on the granted source in the same cycle as its sent.
        sb.push_back(32'h4);
        sb.push_back(32'h4);
        pulse_irq(32'h4);
        wait_issue(n);
        step();
        sent = 1'b1;
        irq  = 32'h4;
        step();
        sent = 1'b0;
        irq  = '0;
        checks++;
        if (pending !== 32'h4) begin
            errors++;
            $display("FAIL race_keep: got pend=%h, required 4", pending);
        end
        serve(2, 1'b0);
        checks++;
        if (pending !== '0 || sb.size() != 0) begin
            errors++;
            $display("FAIL race_done: got pend=%h queued=%0d, required 0 / 0", pending, sb.size());
        end
    endtask

    task automatic test_wait_hold();
        int n;
        int k;
        sb.push_back(32'h20);
        sb.push_back(32'h20);
        pulse_irq(32'h20);
        wait_issue(n);
`ifdef MSI_SCHED_TIMEOUT_EN
        // ISSUE, then 8 silent WAIT cycles, then BACKOFF.
        k = 0;
        while (fail_count === 16'(exp_fail) && k < 50) begin
            step();
            k++;
        end
        exp_fail++;
        checks++;
        if (k != 9 || fail_count !== 16'(exp_fail)) begin
            errors++;
            $display("FAIL timeout: got %0d cycles fc=%0d, required 9 / %0d", k, fail_count, exp_fail);
        end
        serve(2, 1'b0);
`else
        k = 0;
        repeat (40) step();
        checks++;
        if (busy !== 1'b1 || fail_count !== 16'(exp_fail) || pending !== 32'h20) begin
            errors++;
            $display("FAIL wait_hold: got busy=%b fc=%0d pend=%h, required 1 / %0d / 20",
                     busy, fail_count, pending, exp_fail);
        end
        void'(sb.pop_back());
        sent = 1'b1;
        step();
        sent = 1'b0;
`endif
        checks++;
        if (busy !== 1'b0 || pending !== '0) begin
            errors++;
            $display("FAIL wait_done: got busy=%b pend=%h, required 0 / 0 (k=%0d)", busy, pending, k);
        end
    endtask

    task automatic test_async_reset();
        int n;
        sb.push_back(32'h80);
        pulse_irq(32'h80);
        irq = 32'h1;
        wait_issue(n);
        irq = '0;
        #2 rst = 1'b1;
        #1;
        checks++;
        if ({msi_int, pending, busy, fail_count} !== '0) begin
            errors++;
            $display("FAIL async_reset: got int=%h pend=%h busy=%b fc=%0d, required 0",
                     msi_int, pending, busy, fail_count);
        end
        step();
        rst = 1'b0;
        step();
    endtask

    initial begin
        repeat (3) step();
        test_reset();
        rst = 1'b0;
        en  = 4'd1;
        step();
        test_single();
        test_round_robin();
        test_fail_retry();
        test_fold_disable();
        test_merge_race();
        test_wait_hold();
        test_async_reset();
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL sb_drain: got %0d vectors still expected, required 0", sb.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got simulation still running, required finish");
        $fatal(1);
    end

endmodule
